// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared widths, FSM encoding and digit-check helper for the BCD converter
package freq_pkg;

  localparam int NDIG = 10;
  localparam int NBIN = 32;
  localparam int BCDW = NDIG * 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic bad_digits(input logic [BCDW-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (v[i*4 +: 4] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// rtl/bcd_to_bin_if.sv - request/result bundle between a decimal-entry source and the converter
interface bcd_to_bin_if;
  import freq_pkg::*;

  logic            start;
  logic [3:0]      b0, b1, b2, b3, b4, b5, b6, b7, b8, b9;
  logic [NBIN-1:0] bin_out;
  logic            busy;
  logic            done;
  logic            ovf;
  logic            invalid;

  modport master (
    output start, b0, b1, b2, b3, b4, b5, b6, b7, b8, b9,
    input  bin_out, busy, done, ovf, invalid
  );

  modport slave (
    input  start, b0, b1, b2, b3, b4, b5, b6, b7, b8, b9,
    output bin_out, busy, done, ovf, invalid
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - reverse double-dabble correction for one BCD digit
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - iterative BCD-to-binary converter, one bit per clock, with range/format flags
module bcd_to_bin
  import freq_pkg::*;
(
  input logic         clk,
  input logic         rst,
  bcd_to_bin_if.slave bus
);

  state_t          state, state_n;
  logic [BCDW-1:0] bcd_reg, bcd_n;
  logic [NBIN-1:0] bin_reg, bin_n;
  logic [5:0]      cnt, cnt_n;
  logic [NBIN-1:0] bin_q, bin_q_n;
  logic            ovf_q, ovf_n;
  logic            inv_q, inv_n;
  logic            err_q, err_n;

  logic [BCDW-1:0] digits_in;
  logic [BCDW-1:0] bcd_shift;
  logic [BCDW-1:0] bcd_adj;
  logic [NBIN-1:0] bin_shift;

  assign digits_in = {bus.b9, bus.b8, bus.b7, bus.b6, bus.b5,
                      bus.b4, bus.b3, bus.b2, bus.b1, bus.b0};
  assign bcd_shift = {1'b0, bcd_reg[BCDW-1:1]};
  assign bin_shift = {bcd_reg[0], bin_reg[NBIN-1:1]};

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_shift[g*4 +: 4]),
      .dout (bcd_adj[g*4 +: 4])
    );
  end

  always_comb begin
    state_n = state;
    bcd_n   = bcd_reg;
    bin_n   = bin_reg;
    cnt_n   = cnt;
    bin_q_n = bin_q;
    ovf_n   = ovf_q;
    inv_n   = inv_q;
    err_n   = err_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          bcd_n   = digits_in;
          bin_n   = '0;
          cnt_n   = '0;
          err_n   = bad_digits(digits_in);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        // A malformed entry spends one cycle here so done timing stays uniform in shape.
        if (err_q) begin
          bin_q_n = '0;
          ovf_n   = 1'b0;
          inv_n   = 1'b1;
          state_n = DONE;
        end else begin
          bcd_n = bcd_adj;
          bin_n = bin_shift;
          cnt_n = cnt + 6'd1;
          if (cnt == 6'd31) begin
            bin_q_n = bin_shift;
            ovf_n   = |bcd_adj;
            inv_n   = 1'b0;
            state_n = DONE;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      bcd_reg <= bcd_n;
      bin_reg <= bin_n;
      cnt     <= cnt_n;
      bin_q   <= bin_q_n;
      ovf_q   <= ovf_n;
      inv_q   <= inv_n;
      err_q   <= err_n;
    end
  end

  assign bus.bin_out = bin_q;
  assign bus.ovf     = ovf_q;
  assign bus.invalid = inv_q;
  assign bus.busy    = (state == SHIFT) || (state == DONE);
  assign bus.done    = (state == DONE);

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - randomized self-checking bench for bcd_to_bin against a decimal arithmetic model
module tb_bcd_to_bin;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bcd_to_bin_if bus ();

  bcd_to_bin dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_digits(input logic [39:0] v);
    bus.b0 = v[3:0];   bus.b1 = v[7:4];   bus.b2 = v[11:8];  bus.b3 = v[15:12];
    bus.b4 = v[19:16]; bus.b5 = v[23:20]; bus.b6 = v[27:24]; bus.b7 = v[31:28];
    bus.b8 = v[35:32]; bus.b9 = v[39:36];
  endtask

  // Decimal value of the entry and whether any nibble is not a decimal digit.
  task automatic model(input logic [39:0] v, output logic [63:0] n, output bit bad);
    logic [3:0] d;
    n   = 64'd0;
    bad = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      d = v[i*4 +: 4];
      if (d > 4'd9) bad = 1'b1;
      n = n * 64'd10 + 64'(d);
    end
  endtask

  function automatic logic [39:0] rand_digits(input bit allow_bad);
    logic [39:0] v;
    for (int i = 0; i < 10; i++) begin
      if (allow_bad && $urandom_range(0, 15) == 0) v[i*4 +: 4] = 4'(10 + $urandom_range(0, 5));
      else v[i*4 +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  task automatic run(input logic [39:0] v, input bit disturb);
    logic [63:0] n;
    bit          bad;
    int          cyc;
    bit          busy_ok;
    int          extra_done;
    logic [63:0] exp_bin;
    logic [63:0] exp_ovf;
    model(v, n, bad);
    exp_bin = bad ? 64'd0 : {32'd0, n[31:0]};
    exp_ovf = (!bad && n >= 64'h1_0000_0000) ? 64'd1 : 64'd0;
    set_digits(v);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    set_digits(rand_digits(1'b1));
    cyc     = 1;
    busy_ok = bus.busy;
    while (!bus.done && cyc < 40) begin
      if (disturb && (cyc == 5 || cyc == 20)) begin
        bus.start = 1'b1;
        set_digits(rand_digits(1'b0));
      end
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
      if (!bus.busy) busy_ok = 1'b0;
    end
    check("latency", 64'(cyc), bad ? 64'd2 : 64'd33);
    check("bin_out", {32'd0, bus.bin_out}, exp_bin);
    check("ovf", {63'd0, bus.ovf}, exp_ovf);
    check("invalid", {63'd0, bus.invalid}, {63'd0, bad});
    check("busy_during", {63'd0, busy_ok}, 64'd1);
    @(negedge clk);
    check("done_pulse_end", {62'd0, bus.done, bus.busy}, 64'd0);
    if (disturb) begin
      extra_done = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.done) extra_done++;
      end
      check("no_extra_done", 64'(extra_done), 64'd0);
    end
  endtask

  task automatic reset_abort(input logic [39:0] v);
    int dones;
    set_digits(v);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i < 15; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_abort_outputs", {27'd0, bus.bin_out, bus.busy, bus.done, bus.ovf, bus.invalid}, 64'd0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("reset_abort_no_done", 64'(dones), 64'd0);
  endtask

  initial begin
    logic [39:0] directed [7];
    directed[0] = 40'h0000000000;
    directed[1] = 40'h0012345678;
    directed[2] = 40'h4294967295;
    directed[3] = 40'h4294967296;
    directed[4] = 40'h9999999999;
    directed[5] = 40'h000000A000;
    directed[6] = 40'h0012345678;

    bus.start = 1'b0;
    set_digits(40'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", {27'd0, bus.bin_out, bus.busy, bus.done, bus.ovf, bus.invalid}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (directed[i]) run(directed[i], 1'b0);
    run(40'h1234567890, 1'b1);
    run(40'h4294967296, 1'b0);
    reset_abort(40'h0987654321);
    run(40'h0987654321, 1'b0);
    for (int i = 0; i < 25; i++) run(rand_digits(1'b1), (i % 7) == 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
